// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time behind valid/ready handshakes, fixed LATENCY, RISC-V load extension.
// Optional build macro DMEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses with rsp_err.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned AW    = IDX_W + 2;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic          we;
        logic [2:0]    funct3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req_ready_nxt, rsp_valid_nxt;
    req_t             req_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept_c, enter_resp_c;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             f3_ok, misalign, err_c, do_write;
    logic [31:0]      rd_word, rd_shift, load_data, wd_rep, wr_word;
    logic [15:0]      rd_half;
    logic [7:0]       rd_byte;
    logic [3:0]       be;

    // Address bits above the memory size wrap and are never looked at.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    assign accept_c     = req_valid && req_ready;
    assign enter_resp_c = (state == S_ACCESS) && (cnt == '0);

    // State register, latency counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = CNT_INIT;
                end
            end
            S_ACCESS: begin
                if (cnt == '0) state_nxt = S_RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs follow the state being entered so they are registered
    always_comb begin
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        if (state_nxt == S_IDLE) req_ready_nxt = 1'b1;
        if (state_nxt == S_RESP) rsp_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept_c) begin
            req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr[AW-1:0], wdata: req_wdata};
        end
    end

    assign idx  = req_q.addr[AW-1:2];
    assign lane = req_q.addr[1:0];

    // Legal size codes and optional alignment rejection
    always_comb begin
        f3_ok = 1'b0;
        if (req_q.we) begin
            f3_ok = (req_q.funct3 == 3'b000) || (req_q.funct3 == 3'b001) || (req_q.funct3 == 3'b010);
        end else begin
            f3_ok = (req_q.funct3 == 3'b000) || (req_q.funct3 == 3'b001) || (req_q.funct3 == 3'b010) ||
                    (req_q.funct3 == 3'b100) || (req_q.funct3 == 3'b101);
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = ((req_q.funct3[1:0] == 2'b01) && lane[0]) ||
                      ((req_q.funct3[1:0] == 2'b10) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign err_c    = !f3_ok || misalign;
    assign do_write = enter_resp_c && req_q.we && !err_c;

    // Load path: lane select then extension
    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        case (req_q.funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = '0;
        endcase
    end

    // Store path: replicate data across lanes and merge under byte enables
    always_comb begin
        be     = 4'b0000;
        wd_rep = req_q.wdata;
        case (req_q.funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{req_q.wdata[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{req_q.wdata[15:0]}};
            end
            2'b10: begin
                be     = 4'b1111;
                wd_rep = req_q.wdata;
            end
            default: be = 4'b0000;
        endcase
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) wr_word[8*b +: 8] = wd_rep[8*b +: 8];
        end
    end

    // RAM contents survive reset; a reset on the write edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && do_write) mem[idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp_c) begin
            rsp_err   <= err_c;
            rsp_rdata <= (req_q.we || err_c) ? 32'd0 : load_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: handshake timing, load/store sizes, errors, backpressure, reset abort, wrap.
// Expectations for misaligned accesses follow DMEM_MISALIGN_CHECK_EN when it is defined.
module tb_data_mem_responder;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold = cycles of backpressure after rsp_valid rises
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int cyc;
        @(negedge clk);
        check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'hA5A5_A5A5;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(LAT));
        check({tag, "/rdata"}, rsp_rdata, exp_rd);
        check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "/done_req_ready"}, 32'(req_ready), 32'd1);
    endtask

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [31:0] W10_AFTER_MIS = 32'hCAFE_F00D;
`else
    localparam logic [31:0] W10_AFTER_MIS = 32'h0102_0304;
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst/req_ready", 32'(req_ready), 32'd1);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        xact("lw10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

        // Byte store into a zero word, then signed/unsigned/word reads
        xact("sw10z", 1'b1, 3'b010, 32'h10, 32'h0, 32'd0, 1'b0, 0);
        xact("sb13", 1'b1, 3'b000, 32'h13, 32'h1234_5681, 32'd0, 1'b0, 0);
        xact("lb13", 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFF_FF81, 1'b0, 0);
        xact("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h0000_0081, 1'b0, 0);
        xact("lw10b", 1'b0, 3'b010, 32'h10, 32'd0, 32'h8100_0000, 1'b0, 0);
        xact("lh12", 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF_8100, 1'b0, 0);
        xact("lhu12", 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000_8100, 1'b0, 0);

        // Halfword store into the upper lane pair
        xact("sw14", 1'b1, 3'b010, 32'h14, 32'h1122_3344, 32'd0, 1'b0, 0);
        xact("sh16", 1'b1, 3'b001, 32'h16, 32'hAAAA_5566, 32'd0, 1'b0, 0);
        xact("lw14", 1'b0, 3'b010, 32'h14, 32'd0, 32'h5566_3344, 1'b0, 0);
        xact("lh14", 1'b0, 3'b001, 32'h14, 32'd0, 32'h0000_3344, 1'b0, 0);
        xact("lb15", 1'b0, 3'b000, 32'h15, 32'd0, 32'h0000_0033, 1'b0, 0);

        // Backpressure for five cycles
        xact("bp_lw14", 1'b0, 3'b010, 32'h14, 32'd0, 32'h5566_3344, 1'b0, 5);

        // Misaligned word/halfword accesses
        xact("sw10c", 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        xact("sw12_mis", 1'b1, 3'b010, 32'h12, 32'h0102_0304, 32'd0, 1'b1, 0);
        xact("lw12_mis", 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1, 0);
        xact("lh11_mis", 1'b0, 3'b001, 32'h11, 32'd0, 32'd0, 1'b1, 0);
        xact("lhu13_mis", 1'b0, 3'b101, 32'h13, 32'd0, 32'd0, 1'b1, 0);
`else
        xact("sw12_mis", 1'b1, 3'b010, 32'h12, 32'h0102_0304, 32'd0, 1'b0, 0);
        xact("lw12_mis", 1'b0, 3'b010, 32'h12, 32'd0, 32'h0102_0304, 1'b0, 0);
        xact("lh11_mis", 1'b0, 3'b001, 32'h11, 32'd0, 32'h0000_0304, 1'b0, 0);
        xact("lhu13_mis", 1'b0, 3'b101, 32'h13, 32'd0, 32'h0000_0102, 1'b0, 0);
`endif
        xact("lw10_mis", 1'b0, 3'b010, 32'h10, 32'd0, W10_AFTER_MIS, 1'b0, 0);

        // Unsupported funct3 codes: error, zero data, no write
        xact("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 0);
        xact("ld_f3_110", 1'b0, 3'b110, 32'h10, 32'd0, 32'd0, 1'b1, 0);
        xact("ld_f3_111", 1'b0, 3'b111, 32'h10, 32'd0, 32'd0, 1'b1, 0);
        xact("st_f3_011", 1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        xact("st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        xact("lw10_noerrw", 1'b0, 3'b010, 32'h10, 32'd0, W10_AFTER_MIS, 1'b0, 0);

        // Reset landing on the write edge of an in-flight store
        xact("sw20z", 1'b1, 3'b010, 32'h20, 32'h0, 32'd0, 1'b0, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstacc/valid_before", 32'(rsp_valid), 32'd0);
        check("rstacc/ready_before", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstacc/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstacc/req_ready", 32'(req_ready), 32'd1);
        check("rstacc/rsp_rdata", rsp_rdata, 32'd0);
        check("rstacc/rsp_err", 32'(rsp_err), 32'd0);
        xact("lw20_after_rst", 1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 1'b0, 0);
        xact("lw10_after_rst", 1'b0, 3'b010, 32'h10, 32'd0, W10_AFTER_MIS, 1'b0, 0);

        // Address wrap modulo the memory size
        xact("sw_wrap", 1'b1, 3'b010, 32'h0000_1010, 32'h5A5A_0F0F, 32'd0, 1'b0, 0);
        xact("lw10_wrap", 1'b0, 3'b010, 32'h10, 32'd0, 32'h5A5A_0F0F, 1'b0, 0);
        xact("lw_wrap_hi", 1'b0, 3'b010, 32'hFFFF_F010, 32'd0, 32'h5A5A_0F0F, 1'b0, 0);
        xact("ld_wrap_err", 1'b0, 3'b011, 32'h0000_1010, 32'd0, 32'd0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
